// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, bus widths, request/response payloads.
// Used by the request bridge, the delay stage and the APB slaves.
package apb_pkg;

    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_STRB_W = 4;
    localparam int unsigned APB_PROT_W = 3;
    localparam int unsigned APB_CNT_W  = 16;

    localparam logic [APB_PROT_W-1:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Registered request attributes, held for the whole APB transfer
    typedef struct packed {
        logic                  write;
        logic [APB_PROT_W-1:0] prot;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
    } apb_ctrl_t;

    // Response returned upstream
    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
    } apb_resp_t;

    // Strobes only carry meaning for writes; reads present all-zero strobes
    function automatic logic [APB_STRB_W-1:0] strb_for(input logic                  write,
                                                       input logic [APB_STRB_W-1:0] wstrb);
        return write ? wstrb : '0;
    endfunction

endpackage : apb_pkg

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog counter.
// Ports: clk/rst_n; clear zeroes the count; enable increments it;
//        limit is the number of ACCESS cycles allowed; expired_c is high while
//        the count sits on the last permitted cycle (limit-1).
module apb_timeout_cnt
    import apb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [APB_CNT_W-1:0] limit,
    output logic                 expired_c
);

    logic [APB_CNT_W-1:0] cnt_q;
    logic [APB_CNT_W-1:0] cnt_d;

    // Clear has priority so a fresh ACCESS phase always starts from zero
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + APB_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (cnt_q == (limit - APB_CNT_W'(1)));

endmodule : apb_timeout_cnt

// File: rtl/apb_req_bridge.sv
// Converts a valid/ready request/response interface into single APB transfers.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_*                           upstream request (valid/ready handshake)
//   resp_*                          upstream response (valid/ready handshake)
//   apb_paddr..apb_pstrb            registered APB request fields
//   apb_psel, apb_penable           APB phase controls
//   apb_pready/prdata/pslverr       APB completion from downstream
// Transfers that see no pready within TIMEOUT_CYCLES ACCESS cycles are aborted
// and answered with resp_err=1 and zero data.
module apb_req_bridge
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  req_write,
    input  logic [APB_DATA_W-1:0] req_wdata,
    input  logic [APB_STRB_W-1:0] req_wstrb,
    input  logic [APB_PROT_W-1:0] req_prot,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [APB_DATA_W-1:0] resp_rdata,
    output logic                  resp_err,

    output logic [ADDR_W-1:0]     apb_paddr,
    output logic [APB_PROT_W-1:0] apb_pprot,
    output logic                  apb_pwrite,
    output logic [APB_DATA_W-1:0] apb_pwdata,
    output logic [APB_STRB_W-1:0] apb_pstrb,
    output logic                  apb_psel,
    output logic                  apb_penable,
    input  logic                  apb_pready,
    input  logic [APB_DATA_W-1:0] apb_prdata,
    input  logic                  apb_pslverr
);

    localparam logic [APB_CNT_W-1:0] TO_LIMIT = APB_CNT_W'(TIMEOUT_CYCLES);
    localparam apb_ctrl_t CTRL_RST = '{write: 1'b0, prot: PROT_DEFAULT,
                                       wdata: '0, strb: '0};

    apb_state_e          state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                resp_valid_q, resp_valid_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    apb_ctrl_t           ctrl_q, ctrl_d;
    apb_resp_t           resp_q, resp_d;

    logic                to_clear_c;
    logic                to_enable_c;
    logic                to_expired_c;

    // The counter is zeroed during SETUP so it reads 0 on the first ACCESS cycle
    assign to_clear_c  = (state_q == ST_SETUP);
    assign to_enable_c = (state_q == ST_ACCESS) && !apb_pready;

    apb_timeout_cnt u_timeout_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (to_clear_c),
        .enable    (to_enable_c),
        .limit     (TO_LIMIT),
        .expired_c (to_expired_c)
    );

    // Next-state, datapath capture and registered-output decode
    always_comb begin
        state_d = state_q;
        paddr_d = paddr_q;
        ctrl_d  = ctrl_q;
        resp_d  = resp_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d      = ST_SETUP;
                    paddr_d      = req_addr;
                    ctrl_d.write = req_write;
                    ctrl_d.prot  = req_prot;
                    ctrl_d.wdata = req_wdata;
                    ctrl_d.strb  = strb_for(req_write, req_wstrb);
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A completing slave beats the watchdog in the same cycle
                if (apb_pready) begin
                    resp_d.rdata = ctrl_q.write ? '0 : apb_prdata;
                    resp_d.err   = apb_pslverr;
                    state_d      = ST_RESP;
                end else if (to_expired_c) begin
                    resp_d.rdata = '0;
                    resp_d.err   = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are flop-driven
        req_ready_d  = (state_d == ST_IDLE);
        psel_d       = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d    = (state_d == ST_ACCESS);
        resp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            paddr_q      <= '0;
            ctrl_q       <= CTRL_RST;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            resp_valid_q <= resp_valid_d;
            paddr_q      <= paddr_d;
            ctrl_q       <= ctrl_d;
            resp_q       <= resp_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_q.rdata;
    assign resp_err    = resp_q.err;
    assign apb_paddr   = paddr_q;
    assign apb_pprot   = ctrl_q.prot;
    assign apb_pwrite  = ctrl_q.write;
    assign apb_pwdata  = ctrl_q.wdata;
    assign apb_pstrb   = ctrl_q.strb;
    assign apb_psel    = psel_q;
    assign apb_penable = penable_q;

endmodule : apb_req_bridge

// File: tb/tb_apb_req_bridge.sv
// Directed bench for apb_req_bridge (TIMEOUT_CYCLES = 8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_apb_req_bridge;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [2:0]  req_prot;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] apb_paddr;
    logic [2:0]  apb_pprot;
    logic        apb_pwrite;
    logic [31:0] apb_pwdata;
    logic [3:0]  apb_pstrb;
    logic        apb_psel;
    logic        apb_penable;
    logic        apb_pready;
    logic [31:0] apb_prdata;
    logic        apb_pslverr;

    int n_vec;
    int n_err;

    apb_req_bridge #(.TIMEOUT_CYCLES(8), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_write   (req_write),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .req_prot    (req_prot),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .apb_paddr   (apb_paddr),
        .apb_pprot   (apb_pprot),
        .apb_pwrite  (apb_pwrite),
        .apb_pwdata  (apb_pwdata),
        .apb_pstrb   (apb_pstrb),
        .apb_psel    (apb_psel),
        .apb_penable (apb_penable),
        .apb_pready  (apb_pready),
        .apb_prdata  (apb_prdata),
        .apb_pslverr (apb_pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        req_valid   = 1'b0;
        req_addr    = '0;
        req_write   = 1'b0;
        req_wdata   = '0;
        req_wstrb   = '0;
        req_prot    = '0;
        resp_ready  = 1'b0;
        apb_pready  = 1'b0;
        apb_prdata  = '0;
        apb_pslverr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        quiet_inputs();
        repeat (3) tick();
        n_vec++;
        if ({apb_psel, apb_penable, resp_valid, resp_err} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl got psel/pen/rv/err=%b exp 0000",
                     {apb_psel, apb_penable, resp_valid, resp_err});
        end
        n_vec++;
        if ({apb_paddr, apb_pwdata, apb_pstrb, apb_pprot, apb_pwrite, resp_rdata} !== '0) begin
            n_err++;
            $display("FAIL reset_data got paddr=%h pwdata=%h pstrb=%h rdata=%h exp all 0",
                     apb_paddr, apb_pwdata, apb_pstrb, resp_rdata);
        end
        rst_n = 1'b1;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_req_ready got %b exp 1", req_ready);
        end
    endtask

    // Read starting on the first edge after reset release, slave ready immediately
    task automatic test_read();
        req_valid = 1'b1; req_addr = 32'h1000_0004; req_write = 1'b0;
        req_wstrb = 4'hF; req_prot = 3'b010; req_wdata = 32'h5555_AAAA;
        tick();
        req_valid = 1'b0;
        n_vec++;
        if ({apb_psel, apb_penable, req_ready} !== 3'b100 || apb_paddr !== 32'h1000_0004) begin
            n_err++;
            $display("FAIL read_setup got psel/pen/rdy=%b paddr=%h exp 100 10000004",
                     {apb_psel, apb_penable, req_ready}, apb_paddr);
        end
        n_vec++;
        if (apb_pstrb !== 4'h0 || apb_pwrite !== 1'b0 || apb_pprot !== 3'b010) begin
            n_err++;
            $display("FAIL read_fields got pstrb=%h pwrite=%b pprot=%b exp 0 0 010",
                     apb_pstrb, apb_pwrite, apb_pprot);
        end
        apb_pready = 1'b1; apb_prdata = 32'hDEAD_BEEF;
        tick();
        n_vec++;
        if ({apb_psel, apb_penable} !== 2'b11) begin
            n_err++;
            $display("FAIL read_access got psel/pen=%b exp 11", {apb_psel, apb_penable});
        end
        tick();
        apb_pready = 1'b0; apb_prdata = 32'h0;
        n_vec++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF || resp_err !== 1'b0
            || {apb_psel, apb_penable} !== 2'b00) begin
            n_err++;
            $display("FAIL read_resp got rv=%b rdata=%h err=%b psel/pen=%b exp 1 deadbeef 0 00",
                     resp_valid, resp_rdata, resp_err, {apb_psel, apb_penable});
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_vec++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL read_idle got rv=%b rdy=%b exp 0 1", resp_valid, req_ready);
        end
    endtask

    // Slave error plus upstream back-pressure on the response
    task automatic test_slverr_backpressure();
        req_valid = 1'b1; req_addr = 32'h2000_0010; req_write = 1'b0; req_prot = 3'b000;
        tick();
        req_valid = 1'b0;
        tick();
        apb_pready = 1'b1; apb_pslverr = 1'b1; apb_prdata = 32'hCAFE_F00D;
        tick();
        apb_pready = 1'b0; apb_pslverr = 1'b0; apb_prdata = 32'h0;
        req_valid = 1'b1; req_addr = 32'h3000_0000;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (resp_valid !== 1'b1 || resp_err !== 1'b1 || req_ready !== 1'b0
                || resp_rdata !== 32'hCAFE_F00D || apb_psel !== 1'b0) begin
                n_err++;
                $display("FAIL slverr_hold[%0d] got rv=%b err=%b rdy=%b rdata=%h psel=%b exp 1 1 0 cafef00d 0",
                         i, resp_valid, resp_err, req_ready, resp_rdata, apb_psel);
            end
            tick();
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_vec++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || apb_psel !== 1'b0) begin
            n_err++;
            $display("FAIL slverr_release got rv=%b rdy=%b psel=%b exp 0 1 0",
                     resp_valid, req_ready, apb_psel);
        end
    endtask

    // No pready at all: exactly TIMEOUT_CYCLES ACCESS cycles then an error response
    task automatic test_timeout();
        int acc;
        req_valid = 1'b1; req_addr = 32'h4000_0000; req_write = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        acc = 0;
        while (apb_psel && apb_penable && acc < 40) begin
            acc++;
            apb_prdata = 32'hFFFF_0000;
            tick();
        end
        apb_prdata = 32'h0;
        n_vec++;
        if (acc !== 8) begin
            n_err++;
            $display("FAIL timeout_len got %0d ACCESS cycles exp 8", acc);
        end
        n_vec++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0
            || {apb_psel, apb_penable} !== 2'b00) begin
            n_err++;
            $display("FAIL timeout_resp got rv=%b err=%b rdata=%h psel/pen=%b exp 1 1 0 00",
                     resp_valid, resp_err, resp_rdata, {apb_psel, apb_penable});
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    // Write with five wait states; request fields stay stable through ACCESS
    task automatic test_write_wait();
        req_valid = 1'b1; req_addr = 32'h1000_0008; req_write = 1'b1;
        req_wdata = 32'h1234_5678; req_wstrb = 4'h3; req_prot = 3'b001;
        tick();
        req_valid = 1'b0; req_wdata = 32'h0; req_wstrb = 4'h0; req_addr = 32'h0;
        tick();
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if ({apb_psel, apb_penable, apb_pwrite} !== 3'b111 || apb_pwdata !== 32'h1234_5678
                || apb_pstrb !== 4'h3 || apb_paddr !== 32'h1000_0008) begin
                n_err++;
                $display("FAIL write_access[%0d] got ctl=%b pwdata=%h pstrb=%h paddr=%h exp 111 12345678 3 10000008",
                         i, {apb_psel, apb_penable, apb_pwrite}, apb_pwdata, apb_pstrb, apb_paddr);
            end
            apb_pready = (i == 5);
            apb_prdata = 32'h9999_9999;
            tick();
        end
        apb_pready = 1'b0; apb_prdata = 32'h0;
        n_vec++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            n_err++;
            $display("FAIL write_resp got rv=%b rdata=%h err=%b exp 1 0 0",
                     resp_valid, resp_rdata, resp_err);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    // pready arrives on the last permitted ACCESS cycle: normal completion wins
    task automatic test_timeout_boundary();
        req_valid = 1'b1; req_addr = 32'h5000_0000; req_write = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            apb_pready  = (i == 7);
            apb_prdata  = 32'h0BAD_F00D;
            apb_pslverr = 1'b0;
            tick();
        end
        apb_pready = 1'b0; apb_prdata = 32'h0;
        n_vec++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0BAD_F00D) begin
            n_err++;
            $display("FAIL to_boundary got rv=%b err=%b rdata=%h exp 1 0 0badf00d",
                     resp_valid, resp_err, resp_rdata);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    // Asynchronous reset in ACCESS, then a clean read
    task automatic test_reset_mid();
        req_valid = 1'b1; req_addr = 32'h6000_0000; req_write = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({apb_psel, apb_penable, resp_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mid_async got psel/pen/rv=%b exp 000",
                     {apb_psel, apb_penable, resp_valid});
        end
        tick();
        rst_n = 1'b1;
        resp_ready = 1'b1;
        tick();
        tick();
        resp_ready = 1'b0;
        n_vec++;
        if ({apb_psel, resp_valid, req_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL reset_mid_quiet got psel/rv/rdy=%b exp 001",
                     {apb_psel, resp_valid, req_ready});
        end
        req_valid = 1'b1; req_addr = 32'h6000_0040; req_write = 1'b0;
        tick();
        req_valid = 1'b0;
        apb_pready = 1'b1; apb_prdata = 32'h1122_3344;
        tick();
        tick();
        apb_pready = 1'b0; apb_prdata = 32'h0;
        n_vec++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h1122_3344 || resp_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_read got rv=%b rdata=%h err=%b exp 1 11223344 0",
                     resp_valid, resp_rdata, resp_err);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    // Minimum-length transactions back to back
    task automatic test_back_to_back();
        req_valid = 1'b1; req_addr = 32'h7000_0000; req_write = 1'b0;
        apb_pready = 1'b1; apb_prdata = 32'hA5A5_A5A5; resp_ready = 1'b1;
        tick();
        n_vec++;
        if ({apb_psel, apb_penable} !== 2'b10 || apb_paddr !== 32'h7000_0000) begin
            n_err++;
            $display("FAIL b2b_setup1 got psel/pen=%b paddr=%h exp 10 70000000",
                     {apb_psel, apb_penable}, apb_paddr);
        end
        req_addr = 32'h7000_0100;
        tick();
        tick();
        n_vec++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'hA5A5_A5A5) begin
            n_err++;
            $display("FAIL b2b_resp1 got rv=%b rdata=%h exp 1 a5a5a5a5", resp_valid, resp_rdata);
        end
        tick();
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || apb_psel !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle got rdy=%b rv=%b psel=%b exp 1 0 0", req_ready, resp_valid, apb_psel);
        end
        tick();
        req_valid = 1'b0;
        n_vec++;
        if ({apb_psel, apb_penable} !== 2'b10 || apb_paddr !== 32'h7000_0100) begin
            n_err++;
            $display("FAIL b2b_setup2 got psel/pen=%b paddr=%h exp 10 70000100",
                     {apb_psel, apb_penable}, apb_paddr);
        end
        tick();
        tick();
        tick();
        apb_pready = 1'b0; resp_ready = 1'b0; apb_prdata = 32'h0;
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end got rdy=%b rv=%b exp 1 0", req_ready, resp_valid);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        quiet_inputs();
        test_reset();
        test_read();
        test_slverr_backpressure();
        test_timeout();
        test_write_wait();
        test_timeout_boundary();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_apb_req_bridge
